// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster generator (640x480@60 by default).
// Two counters (h, v) plus sync/blanking/pulse flags. Every flag is decoded
// from the *next* counter value and registered on the same edge as the
// counters, so all outputs describe the current (x, y) with zero skew.
// No handshake: ena is a plain advance qualifier, outputs hold while ena=0.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Both totals must fit the 10-bit counters.
  if (H_TOTAL > 1024) begin : g_bad_h_total
    $fatal(1, "vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_bad_v_total
    $fatal(1, "vga_timing_gen: V_TOTAL exceeds 1024");
  end

  // Region boundaries held at 11 bits so an end value of 1024 still compares.
  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  h_nxt;
  logic [9:0]  v_nxt;
  logic [10:0] h_nxt_w;
  logic [10:0] v_nxt_w;
  logic        hsync_nxt;
  logic        vsync_nxt;
  logic        display_on_nxt;
  logic        line_start_nxt;
  logic        frame_start_nxt;

  // Next raster position and the flags that describe it.
  always_comb begin
    h_nxt = x + 10'd1;
    v_nxt = y;
    if (x == H_LAST) begin
      h_nxt = 10'd0;
      v_nxt = (y == V_LAST) ? 10'd0 : y + 10'd1;
    end
    h_nxt_w         = {1'b0, h_nxt};
    v_nxt_w         = {1'b0, v_nxt};
    hsync_nxt       = !((h_nxt_w >= HS_START) && (h_nxt_w < HS_END));
    // v only moves on the h wrap, so vsync only changes at h = 0.
    vsync_nxt       = !((v_nxt_w >= VS_START) && (v_nxt_w < VS_END));
    display_on_nxt  = (h_nxt_w < H_ACT_END) && (v_nxt_w < V_ACT_END);
    line_start_nxt  = (h_nxt == 10'd0);
    frame_start_nxt = (h_nxt == 10'd0) && (v_nxt == 10'd0);
  end

  // Counters and flags advance together on enabled edges; reset lands on (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= 10'd0;
      y           <= 10'd0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      display_on  <= 1'b1;
      line_start  <= 1'b1;
      frame_start <= 1'b1;
    end else if (ena) begin
      x           <= h_nxt;
      y           <= v_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      display_on  <= display_on_nxt;
      line_start  <= line_start_nxt;
      frame_start <= frame_start_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: self-checking bench for vga_timing_gen.
// Horizontal timing uses the real 640-wide line; the vertical geometry is
// shrunk (8 active lines, same 2-line sync) so full frames stay short.
module tb_vga_timing_gen;

  localparam int VA    = 8;
  localparam int VF    = 2;
  localparam int VS    = 2;
  localparam int VB    = 3;
  localparam int VT    = VA + VF + VS + VB;
  localparam int HT    = 800;
  localparam int FRAME = HT * VT;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [9:0] x;
  logic [9:0] y;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic       line_start;
  logic       frame_start;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference position of the raster.
  int mh = 0;
  int mv = 0;

  vga_timing_gen #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(VA),  .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .x(x), .y(y), .hsync(hsync), .vsync(vsync),
    .display_on(display_on), .line_start(line_start), .frame_start(frame_start)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Expected output bundle {x, y, hsync, vsync, display_on, line_start, frame_start}
  // straight from the raster rules.
  function automatic logic [25:0] model_vec(input int h, input int v);
    logic hs, vs_l, de, ls, fs;
    hs   = !(h >= 656 && h < 752);
    vs_l = !(v >= VA + VF && v < VA + VF + VS);
    de   = (h < 640) && (v < VA);
    ls   = (h == 0);
    fs   = (h == 0) && (v == 0);
    return {10'(h), 10'(v), hs, vs_l, de, ls, fs};
  endfunction

  function automatic void model_advance();
    mh = mh + 1;
    if (mh == HT) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end
  endfunction

  function automatic logic [25:0] obs_vec();
    return {x, y, hsync, vsync, display_on, line_start, frame_start};
  endfunction

  // ---------------- driver ----------------
  // One clock with the given enable; outputs sampled 1 time unit after the edge.
  task automatic step(input logic e);
    ena = e;
    @(posedge clk);
    #1;
    if (e) model_advance();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [25:0] o;
    rst_n = 1'b0;
    ena   = 1'b0;
    #12;
    o = obs_vec();
    tests_run++;
    if (o !== model_vec(0, 0)) begin
      tests_failed++;
      $display("FAIL reset_initial got=%h exp=%h", o, model_vec(0, 0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    mh = 0; mv = 0;
    // Walk to (300,5), checking every pixel.
    for (int i = 0; i < 5 * HT + 300; i++) begin
      step(1'b1);
      o = obs_vec();
      tests_run++;
      if (o !== model_vec(mh, mv)) begin
        tests_failed++;
        if (tests_failed < 20) $display("FAIL reset_walk got=%h exp=%h", o, model_vec(mh, mv));
      end
    end
    tests_run++;
    if (x !== 10'd300 || y !== 10'd5) begin
      tests_failed++;
      $display("FAIL reset_walk_pos got=(%0d,%0d) exp=(300,5)", x, y);
    end
    // Asynchronous reset mid-cycle: outputs snap to (0,0) without a clock edge.
    #3;
    rst_n = 1'b0;
    #1;
    o = obs_vec();
    tests_run++;
    if (o !== model_vec(0, 0)) begin
      tests_failed++;
      $display("FAIL reset_async got=%h exp=%h", o, model_vec(0, 0));
    end
    mh = 0; mv = 0;
    ena = 1'b1;
    @(posedge clk);
    #1;
    o = obs_vec();
    tests_run++;
    if (o !== model_vec(0, 0)) begin
      tests_failed++;
      $display("FAIL reset_hold got=%h exp=%h", o, model_vec(0, 0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1);
    tests_run++;
    if (x !== 10'd1 || y !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_first_advance got=(%0d,%0d) exp=(1,0)", x, y);
    end
  endtask

  task automatic test_line();
    logic [25:0] o;
    int start_y, hs_low, hs_first, de_low, steps;
    start_y  = mv;
    hs_low   = 0;
    hs_first = -1;
    de_low   = 0;
    steps    = 0;
    // Finish the current line (we start at x=1), then one full line.
    while (!(mh == 0 && steps > 0) && steps < 2 * HT) begin
      step(1'b1);
      steps++;
    end
    tests_run++;
    if (y !== 10'(start_y + 1) || x !== 10'd0) begin
      tests_failed++;
      $display("FAIL line_wrap got=(%0d,%0d) exp=(0,%0d)", x, y, start_y + 1);
    end
    for (int c = 0; c < HT; c++) begin
      if (!hsync) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(x);
      end
      if (!display_on) de_low++;
      step(1'b1);
      o = obs_vec();
      tests_run++;
      if (o !== model_vec(mh, mv)) begin
        tests_failed++;
        if (tests_failed < 20) $display("FAIL line_model got=%h exp=%h", o, model_vec(mh, mv));
      end
    end
    tests_run++;
    if (hs_low != 96) begin
      tests_failed++;
      $display("FAIL line_hsync_width got=%0d exp=96", hs_low);
    end
    tests_run++;
    if (hs_first != 656) begin
      tests_failed++;
      $display("FAIL line_hsync_start got=%0d exp=656", hs_first);
    end
    tests_run++;
    if (de_low != 160) begin
      tests_failed++;
      $display("FAIL line_display_off got=%0d exp=160", de_low);
    end
    tests_run++;
    if (x !== 10'd0 || y !== 10'(start_y + 2)) begin
      tests_failed++;
      $display("FAIL line_period got=(%0d,%0d) exp=(0,%0d)", x, y, start_y + 2);
    end
  endtask

  task automatic test_frame();
    logic [25:0] o;
    int guard, vlow, rises, fs_cnt, vlow_x, vlow_y;
    logic prev_vs;
    guard = 0;
    while (frame_start !== 1'b1 && guard < FRAME + HT) begin
      step(1'b1);
      guard++;
    end
    tests_run++;
    if (frame_start !== 1'b1) begin
      tests_failed++;
      $display("FAIL frame_find_start got=%b exp=1", frame_start);
    end
    for (int f = 0; f < 2; f++) begin
      vlow = 0; rises = 0; fs_cnt = 0; vlow_x = -1; vlow_y = -1;
      prev_vs = vsync;
      for (int c = 0; c < FRAME; c++) begin
        if (!vsync) begin
          if (vlow == 0) begin vlow_x = int'(x); vlow_y = int'(y); end
          vlow++;
        end
        if (frame_start) fs_cnt++;
        if (!prev_vs && vsync) begin
          rises++;
          tests_run++;
          if (x !== 10'd0 || y !== 10'(VA + VF + VS)) begin
            tests_failed++;
            $display("FAIL frame_vsync_rise_pos got=(%0d,%0d) exp=(0,%0d)", x, y, VA + VF + VS);
          end
        end
        prev_vs = vsync;
        step(1'b1);
        o = obs_vec();
        tests_run++;
        if (o !== model_vec(mh, mv)) begin
          tests_failed++;
          if (tests_failed < 20) $display("FAIL frame_model got=%h exp=%h", o, model_vec(mh, mv));
        end
      end
      tests_run++;
      if (vlow != VS * HT) begin
        tests_failed++;
        $display("FAIL frame_vsync_width got=%0d exp=%0d", vlow, VS * HT);
      end
      tests_run++;
      if (vlow_x != 0 || vlow_y != VA + VF) begin
        tests_failed++;
        $display("FAIL frame_vsync_fall got=(%0d,%0d) exp=(0,%0d)", vlow_x, vlow_y, VA + VF);
      end
      tests_run++;
      if (rises != 1) begin
        tests_failed++;
        $display("FAIL frame_vsync_rises got=%0d exp=1", rises);
      end
      tests_run++;
      if (fs_cnt != 1) begin
        tests_failed++;
        $display("FAIL frame_start_count got=%0d exp=1", fs_cnt);
      end
      tests_run++;
      if (x !== 10'd0 || y !== 10'd0 || frame_start !== 1'b1) begin
        tests_failed++;
        $display("FAIL frame_period got=(%0d,%0d,fs=%b) exp=(0,0,fs=1)", x, y, frame_start);
      end
    end
  endtask

  task automatic test_ena_gating();
    logic [25:0] o, prev;
    int start_y;
    logic e;
    start_y = mv;
    // 1,0,0,1 pattern: 800 enabled cycles in 1600 clocks.
    for (int c = 0; c < 2 * HT; c++) begin
      e = ((c % 4) == 0) || ((c % 4) == 3);
      prev = obs_vec();
      step(e);
      o = obs_vec();
      tests_run++;
      if (o !== model_vec(mh, mv) || (!e && o !== prev)) begin
        tests_failed++;
        if (tests_failed < 20) $display("FAIL ena_pattern got=%h exp=%h", o, model_vec(mh, mv));
      end
    end
    tests_run++;
    if (x !== 10'd0 || y !== 10'(start_y + 1)) begin
      tests_failed++;
      $display("FAIL ena_line_period got=(%0d,%0d) exp=(0,%0d)", x, y, start_y + 1);
    end
    // Random enable.
    for (int c = 0; c < 600; c++) begin
      e = 1'($urandom_range(0, 1));
      prev = obs_vec();
      step(e);
      o = obs_vec();
      tests_run++;
      if (o !== model_vec(mh, mv) || (!e && o !== prev)) begin
        tests_failed++;
        if (tests_failed < 20) $display("FAIL ena_random got=%h exp=%h", o, model_vec(mh, mv));
      end
    end
  endtask

  task automatic test_wrap();
    logic [25:0] o;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    mh = 0; mv = 0;
    for (int c = 0; c < FRAME - 1; c++) begin
      step(1'b1);
      o = obs_vec();
      tests_run++;
      if (o !== model_vec(mh, mv)) begin
        tests_failed++;
        if (tests_failed < 20) $display("FAIL wrap_walk got=%h exp=%h", o, model_vec(mh, mv));
      end
    end
    tests_run++;
    if (x !== 10'd799 || y !== 10'(VT - 1) || display_on !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_corner got=(%0d,%0d,de=%b) exp=(799,%0d,de=0)", x, y, display_on, VT - 1);
    end
    step(1'b1);
    tests_run++;
    if (x !== 10'd0 || y !== 10'd0 || vsync !== 1'b1 || display_on !== 1'b1 || frame_start !== 1'b1 || line_start !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_to_origin got=(%0d,%0d,vs=%b,de=%b,fs=%b,ls=%b) exp=(0,0,1,1,1,1)",
               x, y, vsync, display_on, frame_start, line_start);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    ena   = 1'b0;
    test_reset();
    test_line();
    test_frame();
    test_ena_gating();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
